// File: rtl/hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hazard_ctrl                                                |
// | Description : Execute-stage hazard controller for the 5-stage core.      |
// |               Tracks EX/MEM/WB destinations in a shadow pipeline and     |
// |               produces registered forward-select codes, the load-use     |
// |               stall and the taken-branch flush/bubble controls.          |
// |               Optional macro HAZARD_PERF_CNT_EN adds stall/flush         |
// |               performance counters.                                      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module hazard_ctrl #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [REG_AW-1:0] i_id_rs1_addr,
   input  logic [REG_AW-1:0] i_id_rs2_addr,
   input  logic              i_id_rs1_used,
   input  logic              i_id_rs2_used,
   input  logic              i_id_imme_sel,
   input  logic [REG_AW-1:0] i_id_rd_addr,
   input  logic              i_id_rd_wren,
   input  logic              i_id_mem_rden,
   input  logic              i_ex_br_taken,
   input  logic              i_pipe_hold,
   output logic [1:0]        o_forward_A,
   output logic [1:0]        o_forward_B,
   output logic              o_stall_if_id,
   output logic              o_flush_if_id,
   output logic              o_flush_id_ex,
   output logic [CNT_W-1:0]  o_stall_cnt,
   output logic [CNT_W-1:0]  o_flush_cnt
);

   localparam logic [1:0] c_FWD_REG = 2'd0;
   localparam logic [1:0] c_FWD_WB  = 2'd1;
   localparam logic [1:0] c_FWD_MEM = 2'd2;

   // Shadow pipeline entries
   logic [REG_AW-1:0] r_ex_rd;
   logic              r_ex_wren;
   logic              r_ex_load;
   logic [REG_AW-1:0] r_mem_rd;
   logic              r_mem_wren;
   logic              r_mem_load;
   logic [REG_AW-1:0] r_wb_rd;
   logic              r_wb_wren;

   logic [1:0]        r_forward_a;
   logic [1:0]        r_forward_b;

   logic [1:0]        w_fwd_a;
   logic [1:0]        w_fwd_b;
   logic              w_rs2_reg;
   logic              w_load_use;
   logic              w_active;

   // The WB entry and the MEM load flag are kept for a complete shadow of the
   // pipe; the write-first register file makes them unnecessary for steering.
   logic              w_unused_shadow;
   assign w_unused_shadow = ^{r_wb_rd, r_wb_wren, r_mem_load};

   // Forward code for one source as seen after the next edge: the current EX
   // entry will sit in MEM (code 2), the current MEM entry in WB (code 1).
   // A load in EX never forwards; that case is resolved by the load-use bubble.
   function automatic logic [1:0] fwd_code(input logic [REG_AW-1:0] src,
                                           input logic              used);
      logic [1:0] code;
      code = c_FWD_REG;
      if (used && (src != '0)) begin
         if (r_ex_wren && !r_ex_load && (r_ex_rd == src)) begin
            code = c_FWD_MEM;
         end else if (r_mem_wren && (r_mem_rd == src)) begin
            code = c_FWD_WB;
         end
      end
      return code;
   endfunction

   // Forward codes, load-use detection and same-cycle stall/flush controls
   always_comb begin
      w_rs2_reg  = i_id_rs2_used && !i_id_imme_sel;
      w_fwd_a    = fwd_code(i_id_rs1_addr, i_id_rs1_used);
      w_fwd_b    = fwd_code(i_id_rs2_addr, w_rs2_reg);
      w_load_use = r_ex_load && r_ex_wren && (r_ex_rd != '0) &&
                   ((i_id_rs1_used && (i_id_rs1_addr == r_ex_rd)) ||
                    (w_rs2_reg     && (i_id_rs2_addr == r_ex_rd)));
      w_active      = i_rst_n && !i_pipe_hold;
      o_flush_if_id = w_active && i_ex_br_taken;
      o_flush_id_ex = w_active && (i_ex_br_taken || w_load_use);
      o_stall_if_id = w_active && w_load_use && !i_ex_br_taken;
   end

   // Shadow pipeline advance and registered forward codes; frozen on hold
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ex_rd     <= '0;
         r_ex_wren   <= 1'b0;
         r_ex_load   <= 1'b0;
         r_mem_rd    <= '0;
         r_mem_wren  <= 1'b0;
         r_mem_load  <= 1'b0;
         r_wb_rd     <= '0;
         r_wb_wren   <= 1'b0;
         r_forward_a <= c_FWD_REG;
         r_forward_b <= c_FWD_REG;
      end else if (!i_pipe_hold) begin
         r_wb_rd    <= r_mem_rd;
         r_wb_wren  <= r_mem_wren;
         r_mem_rd   <= r_ex_rd;
         r_mem_wren <= r_ex_wren;
         r_mem_load <= r_ex_load;
         if (o_flush_id_ex) begin
            r_ex_rd     <= '0;
            r_ex_wren   <= 1'b0;
            r_ex_load   <= 1'b0;
            r_forward_a <= c_FWD_REG;
            r_forward_b <= c_FWD_REG;
         end else begin
            r_ex_rd     <= i_id_rd_addr;
            r_ex_wren   <= i_id_rd_wren;
            r_ex_load   <= i_id_mem_rden;
            r_forward_a <= w_fwd_a;
            r_forward_b <= w_fwd_b;
         end
      end
   end

   assign o_forward_A = r_forward_a;
   assign o_forward_B = r_forward_b;

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   // Count load-use stalls and taken-branch flushes; both wrap naturally
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (o_stall_if_id) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
         if (o_flush_if_id) begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
         end
      end
   end

   assign o_stall_cnt = r_stall_cnt;
   assign o_flush_cnt = r_flush_cnt;
`else
   assign o_stall_cnt = '0;
   assign o_flush_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_hazard_ctrl                                             |
// | Description : Randomized scoreboard bench for hazard_ctrl against an     |
// |               instruction-level model of the in-flight pipeline.         |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_hazard_ctrl;

   localparam int REG_AW = 5;
   localparam int CNT_W  = 32;
   localparam int N_CYC  = 3000;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [REG_AW-1:0] rs1, rs2, rd;
   logic              u1, u2, imme, wren, load, br, hold;
   logic [1:0]        fwd_a, fwd_b;
   logic              stall, fl_ifid, fl_idex;
   logic [CNT_W-1:0]  stall_cnt_o, flush_cnt_o;

   always #5 clk = ~clk;

   hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_id_rs1_addr (rs1),
      .i_id_rs2_addr (rs2),
      .i_id_rs1_used (u1),
      .i_id_rs2_used (u2),
      .i_id_imme_sel (imme),
      .i_id_rd_addr  (rd),
      .i_id_rd_wren  (wren),
      .i_id_mem_rden (load),
      .i_ex_br_taken (br),
      .i_pipe_hold   (hold),
      .o_forward_A   (fwd_a),
      .o_forward_B   (fwd_b),
      .o_stall_if_id (stall),
      .o_flush_if_id (fl_ifid),
      .o_flush_id_ex (fl_idex),
      .o_stall_cnt   (stall_cnt_o),
      .o_flush_cnt   (flush_cnt_o)
   );

   // An instruction in flight, carrying the forward codes it was issued with
   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic              wren;
      logic              load;
      logic [1:0]        fa;
      logic [1:0]        fb;
   } ins_t;

   typedef struct packed {
      logic             stall;
      logic             fif;
      logic             fid;
      logic [1:0]       fa;
      logic [1:0]       fb;
      logic [CNT_W-1:0] sc;
      logic [CNT_W-1:0] fc;
   } exp_t;

   // pipe[0] = EX, pipe[1] = MEM, pipe[2] = WB
   ins_t pipe [3];
   exp_t sb_q [$];
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Youngest older producer of src: one instruction ahead reaches MEM after
   // the edge (code 2), two ahead reaches WB (code 1).
   function automatic logic [1:0] ref_code(input logic [REG_AW-1:0] src, input bit used);
      if (!used || src == '0) return 2'd0;
      for (int d = 0; d < 2; d++) begin
         if (pipe[d].wren && pipe[d].rd == src) return (d == 0) ? 2'd2 : 2'd1;
      end
      return 2'd0;
   endfunction

   // Monitor: every cycle the DUT presents a full output set; compare it
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         chk("stall_if_id", 32'(stall),   32'(e.stall));
         chk("flush_if_id", 32'(fl_ifid), 32'(e.fif));
         chk("flush_id_ex", 32'(fl_idex), 32'(e.fid));
         chk("forward_A",   32'(fwd_a),   32'(e.fa));
         chk("forward_B",   32'(fwd_b),   32'(e.fb));
         chk("stall_cnt",   stall_cnt_o,  e.sc);
         chk("flush_cnt",   flush_cnt_o,  e.fc);
      end
   end

   // Driver and reference model
   initial begin
      logic             p_rst, p_hold, p_bub, p_stall, p_flush;
      ins_t             p_id;
      logic [CNT_W-1:0] m_sc, m_fc;
      logic             lu, active, e_stall, e_fif, e_fid;
      logic [1:0]       e_fa, e_fb;
      exp_t             e;

      rst_n = 1'b0; rs1 = '0; rs2 = '0; rd = '0;
      u1 = 1'b0; u2 = 1'b0; imme = 1'b0; wren = 1'b0; load = 1'b0;
      br = 1'b0; hold = 1'b0;
      for (int d = 0; d < 3; d++) pipe[d] = '0;
      p_rst = 1'b0; p_hold = 1'b0; p_bub = 1'b0; p_stall = 1'b0; p_flush = 1'b0;
      p_id = '0; m_sc = '0; m_fc = '0;

      for (int cyc = 0; cyc < N_CYC; cyc++) begin
         @(posedge clk);
         #1;
         if (p_rst && !p_hold) begin
            if (p_stall) m_sc = m_sc + 1'b1;
            if (p_flush) m_fc = m_fc + 1'b1;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = p_bub ? ins_t'('0) : p_id;
         end

         rst_n = (cyc < 2) ? 1'b0 : ($urandom_range(0, 149) != 0);
         if (!rst_n) begin
            for (int d = 0; d < 3; d++) pipe[d] = '0;
            m_sc = '0;
            m_fc = '0;
         end

         rs1  = REG_AW'($urandom_range(0, 3));
         rs2  = REG_AW'($urandom_range(0, 3));
         rd   = REG_AW'($urandom_range(0, 3));
         u1   = ($urandom_range(0, 3) != 0);
         u2   = ($urandom_range(0, 3) != 0);
         imme = ($urandom_range(0, 3) == 0);
         wren = ($urandom_range(0, 3) != 0);
         load = wren && ($urandom_range(0, 2) == 0);
         br   = ($urandom_range(0, 7) == 0);
         hold = ($urandom_range(0, 5) == 0);

         lu = pipe[0].load && pipe[0].wren && (pipe[0].rd != '0) &&
              ((u1 && rs1 == pipe[0].rd) || (u2 && !imme && rs2 == pipe[0].rd));
         active  = rst_n && !hold;
         e_stall = active && lu && !br;
         e_fif   = active && br;
         e_fid   = active && (br || lu);
         e_fa    = ref_code(rs1, u1);
         e_fb    = ref_code(rs2, u2 && !imme);

         e.stall = e_stall;
         e.fif   = e_fif;
         e.fid   = e_fid;
         e.fa    = pipe[0].fa;
         e.fb    = pipe[0].fb;
`ifdef HAZARD_PERF_CNT_EN
         e.sc    = m_sc;
         e.fc    = m_fc;
`else
         e.sc    = '0;
         e.fc    = '0;
`endif
         sb_q.push_back(e);

         p_rst   = rst_n;
         p_hold  = hold;
         p_bub   = e_fid;
         p_stall = e_stall;
         p_flush = e_fif;
         p_id    = '{rd: rd, wren: wren, load: load, fa: e_fa, fb: e_fb};
      end

      for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
      if (sb_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain actual=%0d required=0 pending entries", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
